// File: rtl/stoper_counter.sv
// rtl/stoper_counter.sv - 0..9999 stopwatch counter with debounced start/stop and clear buttons.
// Optional lap-freeze display feature is enabled by defining STOPER_LAP_EN.

module stoper_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic mclk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic          s1_q, s1_d, s2_q, s2_d;
    logic          level_q, level_d, prev_q, prev_d;
    logic          armed_q, armed_d;
    logic [1:0]    vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = btn_raw;
        s2_d    = s1_q;
        vld_d   = {vld_q[0], 1'b1};
        level_d = level_q;
        cnt_d   = cnt_q;
        prev_d  = level_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Presses are armed only once the button has been seen released after
        // reset, so a button held through reset never yields an event.
        armed_d = armed_q | (vld_q[1] & ~s2_q);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            vld_q   <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            vld_q   <= vld_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign press = level_q & ~prev_q & armed_q;
endmodule

module stoper_counter #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [13:0] number,
    output logic        running,
    output logic        overflow
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUNNING, STOPPED, OVERFLOW} state_t;

    state_t        state_q, state_d;
    logic [13:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick, ss_ev, clr_ev;

    stoper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .mclk(mclk), .rst(rst), .btn_raw(btn_start_stop), .press(ss_ev)
    );
    stoper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .mclk(mclk), .rst(rst), .btn_raw(btn_clear), .press(clr_ev)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick    = 1'b0;
        if (state_q == RUNNING) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (tick) begin
            if (count_q == 14'd9999) state_d = OVERFLOW;
            else                     count_d = count_q + 14'd1;
        end
        if (ss_ev) begin
            case (state_q)
                IDLE:    state_d = RUNNING;
                RUNNING: if (state_d != OVERFLOW) state_d = STOPPED;
                STOPPED: state_d = RUNNING;
                default: ;
            endcase
        end
        if (clr_ev) begin
            state_d = IDLE;
            count_d = '0;
            presc_d = '0;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    assign running  = (state_q == RUNNING);
    assign overflow = (state_q == OVERFLOW);

`ifdef STOPER_LAP_EN
    logic        lap_ev, frozen_q, frozen_d;
    logic [13:0] lap_q, lap_d;

    stoper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .mclk(mclk), .rst(rst), .btn_raw(btn_lap), .press(lap_ev)
    );

    always_comb begin
        frozen_d = frozen_q;
        lap_d    = lap_q;
        if (lap_ev && state_q == RUNNING) begin
            frozen_d = ~frozen_q;
            lap_d    = count_q;
        end
        if (clr_ev) frozen_d = 1'b0;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            frozen_q <= 1'b0;
            lap_q    <= '0;
        end else begin
            frozen_q <= frozen_d;
            lap_q    <= lap_d;
        end
    end

    assign number = frozen_q ? lap_q : count_q;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
    assign number = count_q;
`endif
endmodule

// File: tb/tb_stoper_counter.sv
// tb/tb_stoper_counter.sv - directed self-checking bench for stoper_counter (TICK_DIV=4, DEBOUNCE_CYCLES=3).
// Define STOPER_LAP_EN for both bench and RTL to exercise the lap freeze.

module tb_stoper_counter;
    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start_stop = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap = 1'b0;
    logic [13:0] number;
    logic        running;
    logic        overflow;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    stoper_counter #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .mclk(mclk), .rst(rst), .btn_start_stop(btn_start_stop),
        .btn_clear(btn_clear), .btn_lap(btn_lap),
        .number(number), .running(running), .overflow(overflow)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    // Returns 1 ns after rising edge number t.
    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input int n, input int r, input int o);
        chk({tag, "_number"}, 32'(number), 32'(n));
        chk({tag, "_running"}, 32'(running), 32'(r));
        chk({tag, "_overflow"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        // Reset for edges 1..2, then idle.
        at(2);
        chk_all("reset", 0, 0, 0);
        rst = 1'b0;
        at(22);
        chk_all("idle20", 0, 0, 0);

        // Start press after edge 22: state changes at edge 28.
        btn_start_stop = 1'b1;
        at(27);
        chk("start_lat_before", 32'(running), 32'd0);
        at(28);
        chk_all("start_lat", 0, 1, 0);
        at(32);
        btn_start_stop = 1'b0;
        chk("first_inc", 32'(number), 32'd1);
        at(47);
        chk("cnt4", 32'(number), 32'd4);
        at(48);
        chk_all("cnt5", 5, 1, 0);

        // Stop lands at edge 58 with count 7 and prescaler 2.
        at(52);
        btn_start_stop = 1'b1;
        at(57);
        chk_all("pre_stop", 7, 1, 0);
        at(58);
        chk_all("stopped", 7, 0, 0);
        at(60);
        btn_start_stop = 1'b0;
        at(70);
        chk_all("stop_hold", 7, 0, 0);

        // Resume at edge 76; the held prescaler phase gives count 8 at edge 78.
        btn_start_stop = 1'b1;
        at(76);
        chk_all("resume", 7, 1, 0);
        at(77);
        chk("resume_p3", 32'(number), 32'd7);
        at(78);
        btn_start_stop = 1'b0;
        chk("resume_inc", 32'(number), 32'd8);

        // Clear and start together while at 42: clear wins.
        at(210);
        btn_start_stop = 1'b1;
        btn_clear = 1'b1;
        at(215);
        chk_all("pre_clear", 42, 1, 0);
        at(216);
        chk_all("clear_prio", 0, 0, 0);
        at(218);
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        at(230);
        chk_all("clear_idle", 0, 0, 0);

        // Run to saturation: 9999 at edge 40242, overflow at edge 40246.
        at(240);
        btn_start_stop = 1'b1;
        at(250);
        btn_start_stop = 1'b0;
        at(40238);
        chk("cnt9998", 32'(number), 32'd9998);
        at(40245);
        chk_all("pre_ovf", 9999, 1, 0);
        at(40246);
        chk_all("ovf", 9999, 0, 1);
        at(40250);
        btn_start_stop = 1'b1;
        at(40260);
        btn_start_stop = 1'b0;
        at(40270);
        chk_all("ovf_hold", 9999, 0, 1);
        btn_clear = 1'b1;
        at(40275);
        chk("ovf_pre_clear", 32'(overflow), 32'd1);
        at(40276);
        chk_all("ovf_clear", 0, 0, 0);
        at(40280);
        btn_clear = 1'b0;

        // Reset while running with start held: no event once reset releases.
        at(40290);
        btn_start_stop = 1'b1;
        at(40300);
        chk("run_before_rst", 32'(running), 32'd1);
        rst = 1'b1;
        at(40301);
        chk_all("rst_override", 0, 0, 0);
        at(40302);
        rst = 1'b0;
        at(40330);
        chk_all("held_through_rst", 0, 0, 0);
        btn_start_stop = 1'b0;
        at(40340);
        btn_start_stop = 1'b1;
        at(40346);
        chk("rearmed_start", 32'(running), 32'd1);
        at(40350);
        btn_start_stop = 1'b0;

        // Count 10 at edge 40386; lap event lands at edge 40388.
        at(40382);
        btn_lap = 1'b1;
        at(40389);
        chk("lap_capture", 32'(number), 32'd10);
        at(40392);
        btn_lap = 1'b0;
`ifdef STOPER_LAP_EN
        at(40410);
        chk("lap_frozen", 32'(number), 32'd10);
        at(40422);
        btn_lap = 1'b1;
        at(40427);
        chk("lap_frozen40", 32'(number), 32'd10);
        at(40428);
        chk_all("lap_release", 20, 1, 0);
`else
        at(40410);
        chk("lap_ignored", 32'(number), 32'd16);
        at(40422);
        btn_lap = 1'b1;
        at(40428);
        chk_all("lap_ignored2", 20, 1, 0);
`endif
        at(40432);
        btn_lap = 1'b0;
        at(40440);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
